// File: rtl/basic.sv
// Shared core types: address/instruction widths, reset values, fetch-queue entry.
package basic;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef logic [XLEN-1:0] Addr;
  typedef logic [ILEN-1:0] Inst;

  localparam Addr XLEN_ZERO = '0;
  // add x0, x0, x0
  localparam Inst INST_NOP  = 32'h0000_0033;

  typedef struct packed {
    Addr pc;
    Inst inst;
  } FetchEntry;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: in-order circular buffer of {pc, inst} entries.
// Optional same-cycle bypass into an empty queue when FETCHQ_BYPASS_EN is defined.
module fetch_queue
  import basic::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  Addr                        in_pc,
  input  Inst                        in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output Addr                        out_pc,
  output Inst                        out_inst,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  FetchEntry           mem_q [DEPTH];
  logic [PtrW-1:0]     head_q, tail_q;
  logic [CntW-1:0]     count_q;
  logic                empty, full, push, pop;
  FetchEntry           head_entry;

  // Handshakes, head presentation and push/pop decisions.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CntW'(DEPTH));
    in_ready   = !full && !flush;
    out_valid  = !empty && !flush;
    head_entry = mem_q[head_q];
`ifdef FETCHQ_BYPASS_EN
    if (empty && in_valid && !flush) begin
      out_valid  = 1'b1;
      head_entry = '{pc: in_pc, inst: in_inst};
    end
`endif
    out_pc   = out_valid ? head_entry.pc   : XLEN_ZERO;
    out_inst = out_valid ? head_entry.inst : INST_NOP;
    // Only stored entries are popped; a bypassed entry never enters the array.
    pop      = out_valid && out_ready && !empty;
    push     = in_valid && in_ready;
`ifdef FETCHQ_BYPASS_EN
    if (empty && out_ready) push = 1'b0;
`endif
    count    = count_q;
  end

  // Pointer and occupancy state; flush overrides any push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{pc: in_pc, inst: in_inst};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4). Define FETCHQ_BYPASS_EN to test the bypass build.
module tb_fetch_queue;
  import basic::*;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  Addr         in_pc = '0;
  Inst         in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  Addr         out_pc;
  Inst         out_inst;
  logic        flush = 1'b0;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: expected queue contents and occupancy.
  logic [63:0] sb [$];
  int          m_cnt = 0;

  fetch_queue #(.DEPTH(Depth)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: drive at negedge, check combinational outputs, then advance the model.
  task automatic cycle(input logic v, input Addr pc, input Inst inst, input logic ordy,
                       input logic fl);
    logic        exp_rdy, exp_ov, bypass;
    logic [63:0] head;
    @(negedge clk);
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (m_cnt != Depth) && !fl;
    exp_ov  = (m_cnt != 0) && !fl;
    bypass  = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    if (m_cnt == 0 && v && !fl) begin
      exp_ov = 1'b1;
      bypass = 1'b1;
    end
`endif
    head = bypass ? {pc, inst} : (sb.size() != 0 ? sb[0] : 64'h0);
    check_eq("count", 64'(count), 64'(m_cnt));
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check_eq("out_entry", {out_pc, out_inst}, head);
    end else begin
      check_eq("idle_out", {out_pc, out_inst}, {XLEN_ZERO, INST_NOP});
    end
    if (fl) begin
      sb.delete();
      m_cnt = 0;
    end else if (bypass && ordy) begin
      // consumed in flight, never stored
    end else begin
      if (exp_ov && ordy && m_cnt != 0) begin
        void'(sb.pop_front());
        m_cnt--;
      end
      if (v && exp_rdy) begin
        sb.push_back({pc, inst});
        m_cnt++;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    // Reset held: outputs must sit at their idle values.
    #1;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out", {out_pc, out_inst}, {XLEN_ZERO, INST_NOP});
    @(negedge clk);
    reset_n = 1'b1;

    // Single push then observe one cycle later.
    cycle(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill past capacity: fifth push refused.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    idle(1'b0);

    // Full with same-cycle pop: push refused, then accepted next cycle.
    cycle(1'b1, 32'h2000, 32'hB000_0000, 1'b1, 1'b0);
    cycle(1'b1, 32'h2000, 32'hB000_0000, 1'b0, 1'b0);
    idle(1'b0);

    // Drain, queue three, flush alongside a push.
    for (int i = 0; i < 5; i++) idle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h3100, 32'hC100_0000, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Ten push/pop pairs across pointer wrap; occupancy stays small.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b1, 1'b0);
      check_eq("cnt_le2", 64'(count <= 3'd2), 64'd1);
    end
    idle(1'b1);
    idle(1'b1);

`ifdef FETCHQ_BYPASS_EN
    // Empty queue bypass: visible same cycle, not stored.
    cycle(1'b1, 32'h200, 32'h0000_0013, 1'b1, 1'b0);
    idle(1'b0);
`endif

    // Random traffic with occasional flush.
    for (int i = 0; i < 80; i++) begin
      cycle(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-operation discards everything.
    cycle(1'b1, 32'h4000, 32'hE000_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h4004, 32'hE000_0001, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_count", 64'(count), 64'd0);
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    sb.delete();
    m_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
